// File: rtl/z80_bus_pkg.sv
// Shared types for the Z80 bus responder: FSM states, decoded access kinds
// and the reset/float data values.
package z80_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MEM_RD,
    MEM_WR,
    IO_RD,
    IO_WR,
    INTA,
    HOLD
  } bus_state_t;

  typedef enum logic [2:0] {
    ACC_NONE,
    ACC_MEM_RD,
    ACC_MEM_WR,
    ACC_IO_RD,
    ACC_IO_WR,
    ACC_INTA
  } access_t;

  localparam logic [7:0] FLOAT_DATA_DEFAULT = 8'hFF;
  localparam logic [7:0] RESET_DATA         = 8'hFF;

  function automatic logic is_read_state(input bus_state_t s);
    return (s == MEM_RD) || (s == IO_RD);
  endfunction

endpackage

// File: rtl/z80_bus_decode.sv
// Combinational strobe decoder: classifies the current CPU bus strobes into
// an access kind, with interrupt acknowledge taking priority.
module z80_bus_decode
  import z80_bus_pkg::*;
(
  input  logic    m1_n,
  input  logic    mreq_n,
  input  logic    iorq_n,
  input  logic    rd_n,
  input  logic    wr_n,
  input  logic    rfsh_n,
  output access_t access
);

  always_comb begin
    access = ACC_NONE;
    if (!m1_n && !iorq_n)
      access = ACC_INTA;
    // refresh cycles drive mreq_n low with rfsh_n low and must fall through
    else if (!mreq_n && rfsh_n && !rd_n)
      access = ACC_MEM_RD;
    else if (!mreq_n && rfsh_n && !wr_n)
      access = ACC_MEM_WR;
    else if (!iorq_n && m1_n && !rd_n)
      access = ACC_IO_RD;
    else if (!iorq_n && m1_n && !wr_n)
      access = ACC_IO_WR;
  end

endmodule

// File: rtl/z80_bus_responder.sv
// Z80 bus responder: turns CPU strobes into handshaked memory/I/O backend
// requests, stretching the CPU with wait_n until the backend answers.
module z80_bus_responder
  import z80_bus_pkg::*;
#(
  parameter int         TIMEOUT    = 255,
  parameter logic [7:0] FLOAT_DATA = FLOAT_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  input  logic [15:0] A,
  input  logic [7:0]  dout,
  output logic        wait_n,
  output logic [7:0]  di,
  input  logic [7:0]  int_vector,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        io_req,
  output logic        io_we,
  output logic [7:0]  io_addr,
  output logic [7:0]  io_wdata,
  input  logic        io_ack,
  input  logic [7:0]  io_rdata
);

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  access_t    access;
  bus_state_t state_reg, state_next;
  logic        wait_n_reg, wait_n_next;
  logic [7:0]  di_reg, di_next;
  logic        mem_req_reg, mem_req_next;
  logic        mem_we_reg, mem_we_next;
  logic [15:0] mem_addr_reg, mem_addr_next;
  logic [7:0]  mem_wdata_reg, mem_wdata_next;
  logic        io_req_reg, io_req_next;
  logic        io_we_reg, io_we_next;
  logic [7:0]  io_addr_reg, io_addr_next;
  logic [7:0]  io_wdata_reg, io_wdata_next;
  logic [15:0] wait_cnt_reg, wait_cnt_next;
  logic        inta_phase_reg, inta_phase_next;
  logic [15:0] cnt_inc;
  logic        in_mem;
  logic        backend_ack;
  logic [7:0]  backend_rdata;

  z80_bus_decode u_decode (
    .m1_n   (m1_n),
    .mreq_n (mreq_n),
    .iorq_n (iorq_n),
    .rd_n   (rd_n),
    .wr_n   (wr_n),
    .rfsh_n (rfsh_n),
    .access (access)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      wait_n_reg     <= 1'b1;
      di_reg         <= RESET_DATA;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      io_req_reg     <= 1'b0;
      io_we_reg      <= 1'b0;
      io_addr_reg    <= '0;
      io_wdata_reg   <= '0;
      wait_cnt_reg   <= '0;
      inta_phase_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      wait_n_reg     <= wait_n_next;
      di_reg         <= di_next;
      mem_req_reg    <= mem_req_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      io_req_reg     <= io_req_next;
      io_we_reg      <= io_we_next;
      io_addr_reg    <= io_addr_next;
      io_wdata_reg   <= io_wdata_next;
      wait_cnt_reg   <= wait_cnt_next;
      inta_phase_reg <= inta_phase_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    wait_n_next     = wait_n_reg;
    di_next         = di_reg;
    mem_req_next    = mem_req_reg;
    mem_we_next     = mem_we_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    io_req_next     = io_req_reg;
    io_we_next      = io_we_reg;
    io_addr_next    = io_addr_reg;
    io_wdata_next   = io_wdata_reg;
    wait_cnt_next   = wait_cnt_reg;
    inta_phase_next = inta_phase_reg;
    cnt_inc         = wait_cnt_reg + 16'd1;
    in_mem          = (state_reg == MEM_RD) || (state_reg == MEM_WR);
    backend_ack     = in_mem ? mem_ack : io_ack;
    backend_rdata   = in_mem ? mem_rdata : io_rdata;

    case (state_reg)
      IDLE: begin
        wait_cnt_next   = '0;
        inta_phase_next = 1'b0;
        if (access != ACC_NONE) begin
          wait_n_next    = 1'b0;
          mem_addr_next  = A;
          mem_wdata_next = dout;
          io_addr_next   = A[7:0];
          io_wdata_next  = dout;
        end
        case (access)
          ACC_MEM_RD: begin state_next = MEM_RD; mem_req_next = 1'b1; mem_we_next = 1'b0; end
          ACC_MEM_WR: begin state_next = MEM_WR; mem_req_next = 1'b1; mem_we_next = 1'b1; end
          ACC_IO_RD:  begin state_next = IO_RD;  io_req_next  = 1'b1; io_we_next  = 1'b0; end
          ACC_IO_WR:  begin state_next = IO_WR;  io_req_next  = 1'b1; io_we_next  = 1'b1; end
          ACC_INTA:   begin state_next = INTA;   di_next      = int_vector; end
          default: ;
        endcase
      end

      // ack is checked before the timeout so a last-moment answer still wins
      MEM_RD, MEM_WR, IO_RD, IO_WR: begin
        if (backend_ack || (cnt_inc >= TIMEOUT_W)) begin
          state_next   = HOLD;
          wait_n_next  = 1'b1;
          mem_req_next = 1'b0;
          mem_we_next  = 1'b0;
          io_req_next  = 1'b0;
          io_we_next   = 1'b0;
          if (is_read_state(state_reg))
            di_next = backend_ack ? backend_rdata : FLOAT_DATA;
        end else begin
          wait_cnt_next = cnt_inc;
        end
      end

      INTA: begin
        if (inta_phase_reg) begin
          wait_n_next = 1'b1;
          state_next  = HOLD;
        end else begin
          inta_phase_next = 1'b1;
        end
      end

      // wait for the CPU to end the cycle so one access yields one request
      HOLD: begin
        if (mreq_n && iorq_n)
          state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

  assign wait_n    = wait_n_reg;
  assign di        = di_reg;
  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign io_req    = io_req_reg;
  assign io_we     = io_we_reg;
  assign io_addr   = io_addr_reg;
  assign io_wdata  = io_wdata_reg;

endmodule

// File: tb/tb_z80_bus_responder.sv
// Randomized transaction-level bench for z80_bus_responder; expectations come
// from access-level rules (wait length, data source, request count).
module tb_z80_bus_responder;

  localparam int         TO    = 4;
  localparam logic [7:0] FLOAT = 8'hFF;

  localparam int K_MEM_RD = 0;
  localparam int K_MEM_WR = 1;
  localparam int K_IO_RD  = 2;
  localparam int K_IO_WR  = 3;
  localparam int K_INTA   = 4;
  localparam int K_RFSH   = 5;
  localparam int K_NONE   = 6;

  logic        clk;
  logic        reset;
  logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
  logic [15:0] A;
  logic [7:0]  dout;
  logic        wait_n;
  logic [7:0]  di;
  logic [7:0]  int_vector;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        io_req, io_we, io_ack;
  logic [7:0]  io_addr, io_wdata, io_rdata;

  int          n_checks;
  int          n_fail;
  int          n_txn;
  logic [7:0]  model_di;

  z80_bus_responder #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .m1_n       (m1_n),
    .mreq_n     (mreq_n),
    .iorq_n     (iorq_n),
    .rd_n       (rd_n),
    .wr_n       (wr_n),
    .rfsh_n     (rfsh_n),
    .A          (A),
    .dout       (dout),
    .wait_n     (wait_n),
    .di         (di),
    .int_vector (int_vector),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .io_req     (io_req),
    .io_we      (io_we),
    .io_addr    (io_addr),
    .io_wdata   (io_wdata),
    .io_ack     (io_ack),
    .io_rdata   (io_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (txn %0d)", tag, got, exp, n_txn);
    end
  endtask

  task automatic drive_strobes(input int kind);
    m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
    case (kind)
      K_MEM_RD: begin mreq_n = 1'b0; rd_n = 1'b0; m1_n = 1'($urandom_range(0, 1)); end
      K_MEM_WR: begin mreq_n = 1'b0; wr_n = 1'b0; end
      K_IO_RD:  begin iorq_n = 1'b0; rd_n = 1'b0; end
      K_IO_WR:  begin iorq_n = 1'b0; wr_n = 1'b0; end
      K_INTA:   begin m1_n = 1'b0; iorq_n = 1'b0; end
      K_RFSH:   begin mreq_n = 1'b0; rfsh_n = 1'b0; end
      default: ;
    endcase
  endtask

  // lat = cycles of request visible before the backend raises ack
  task automatic do_access(input int kind, input logic [15:0] addr, input logic [7:0] wdata,
                           input logic [7:0] rdata, input int lat, input bit abort, input int hold);
    int low_cnt = 0, mem_rise = 0, io_rise = 0, req_seen = 0, stab_err = 0, hold_left;
    int exp_low, exp_mem, exp_io;
    bit released = 0, seen_low = 0, cap_valid = 0, rel, ack_now;
    bit is_mem, is_backend, is_wr, is_rd, answered;
    logic prev_mem, prev_io, obs_req, obs_we, cap_we;
    logic [15:0] obs_addr, cap_addr, exp_addr;
    logic [7:0]  obs_wd, cap_wd;

    n_txn++;
    hold_left  = hold;
    is_mem     = (kind == K_MEM_RD) || (kind == K_MEM_WR);
    is_backend = kind <= K_IO_WR;
    is_wr      = (kind == K_MEM_WR) || (kind == K_IO_WR);
    is_rd      = (kind == K_MEM_RD) || (kind == K_IO_RD);
    exp_addr   = is_mem ? addr : {8'h00, addr[7:0]};
    cap_addr = '0; cap_wd = '0; cap_we = 1'b0;

    @(negedge clk);
    A = addr; dout = wdata;
    drive_strobes(kind);
    prev_mem = mem_req; prev_io = io_req;

    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      if (!wait_n) begin low_cnt++; seen_low = 1; end
      if (mem_req && !prev_mem) mem_rise++;
      if (io_req && !prev_io) io_rise++;
      prev_mem = mem_req; prev_io = io_req;
      obs_req  = is_mem ? mem_req : io_req;

      mem_ack = 1'($urandom_range(0, 1)); mem_rdata = 8'($urandom);
      io_ack  = 1'($urandom_range(0, 1)); io_rdata  = 8'($urandom);
      if (is_backend && obs_req) begin
        obs_addr = is_mem ? mem_addr : {8'h00, io_addr};
        obs_wd   = is_mem ? mem_wdata : io_wdata;
        obs_we   = is_mem ? mem_we : io_we;
        if (!cap_valid) begin
          cap_valid = 1; cap_addr = obs_addr; cap_wd = obs_wd; cap_we = obs_we;
        end else if (obs_addr !== cap_addr || obs_wd !== cap_wd || obs_we !== cap_we) begin
          stab_err++;
        end
        ack_now = (req_seen == lat);
        req_seen++;
        if (is_mem) begin mem_ack = ack_now; if (ack_now) mem_rdata = rdata; end
        else begin io_ack = ack_now; if (ack_now) io_rdata = rdata; end
      end

      if (!released) begin
        rel = 0;
        if (abort) rel = 1;
        else if (kind == K_RFSH) rel = (cyc >= 1);
        else if (seen_low && wait_n) begin
          if (hold_left == 0) rel = 1; else hold_left--;
        end
        if (rel) begin
          drive_strobes(K_NONE);
          A = 16'($urandom); dout = 8'($urandom);
          released = 1;
        end
      end
    end
    drive_strobes(K_NONE);

    answered = (lat + 1) <= TO;
    if (is_backend)          exp_low = answered ? lat + 1 : TO;
    else if (kind == K_INTA) exp_low = 2;
    else                     exp_low = 0;
    exp_mem = is_mem ? 1 : 0;
    exp_io  = (is_backend && !is_mem) ? 1 : 0;
    if (is_rd)          model_di = answered ? rdata : FLOAT;
    if (kind == K_INTA) model_di = int_vector;

    check_value("wait_low_cycles", 32'(low_cnt), 32'(exp_low));
    check_value("mem_req_pulses", 32'(mem_rise), 32'(exp_mem));
    check_value("io_req_pulses", 32'(io_rise), 32'(exp_io));
    check_value("di", 32'(di), 32'(model_di));
    check_value("idle_wait_n", 32'(wait_n), 32'd1);
    check_value("idle_req", 32'({mem_req, io_req}), 32'd0);
    if (is_backend) begin
      check_value("req_addr", 32'(cap_addr), 32'(exp_addr));
      check_value("req_we", 32'(cap_we), 32'(is_wr));
      check_value("req_stable", 32'(stab_err), 32'd0);
      if (is_wr) check_value("req_wdata", 32'(cap_wd), 32'(wdata));
    end
    $display("txn %0d kind=%0d addr=%h lat=%0d abort=%0d hold=%0d wait_low=%0d di=%h",
             n_txn, kind, addr, lat, abort, hold, low_cnt, di);
  endtask

  task automatic reset_mid_write();
    n_txn++;
    @(negedge clk);
    A = 16'h2468; dout = 8'hAB; mem_ack = 1'b0; io_ack = 1'b0;
    drive_strobes(K_MEM_WR);
    @(negedge clk);
    check_value("rst_pre_req", 32'(mem_req), 32'd1);
    #2;
    reset = 1'b1;
    drive_strobes(K_NONE);
    #1;
    check_value("rst_async_req", 32'(mem_req), 32'd0);
    check_value("rst_async_wait", 32'(wait_n), 32'd1);
    check_value("rst_async_addr", 32'(mem_addr), 32'd0);
    model_di = 8'hFF;
    @(negedge clk);
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h99;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_value("rst_late_ack_req", 32'(mem_req), 32'd0);
      check_value("rst_late_ack_wait", 32'(wait_n), 32'd1);
      check_value("rst_late_ack_di", 32'(di), 32'(model_di));
    end
    mem_ack = 1'b0;
    $display("txn %0d reset during pending memory write", n_txn);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; n_txn = 0;
    model_di = 8'hFF;
    reset = 1'b1;
    drive_strobes(K_NONE);
    A = '0; dout = '0; int_vector = 8'h00;
    mem_ack = 1'b0; mem_rdata = '0; io_ack = 1'b0; io_rdata = '0;
    #1;
    check_value("reset_wait_n", 32'(wait_n), 32'd1);
    check_value("reset_di", 32'(di), 32'hFF);
    check_value("reset_reqs", 32'({mem_req, io_req, mem_we, io_we}), 32'd0);
    check_value("reset_addrs", 32'({mem_addr, io_addr}), 32'd0);
    check_value("reset_wdata", 32'({mem_wdata, io_wdata}), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    do_access(K_MEM_RD, 16'h4000, 8'h00, 8'h5A, 2, 0, 0);
    do_access(K_IO_WR, 16'h00FE, 8'h07, 8'h00, 0, 0, 0);
    int_vector = 8'hC3;
    do_access(K_INTA, 16'h0038, 8'h00, 8'h00, 0, 0, 1);
    do_access(K_MEM_RD, 16'h1234, 8'h00, 8'h77, 50, 0, 0);
    do_access(K_RFSH, 16'h0080, 8'h00, 8'h00, 0, 0, 0);
    do_access(K_IO_RD, 16'h3412, 8'h00, 8'h3C, TO - 1, 0, 1);
    do_access(K_MEM_WR, 16'hBEEF, 8'h5E, 8'h00, 1, 1, 0);
    reset_mid_write();
    do_access(K_MEM_RD, 16'h8001, 8'h00, 8'hA5, 1, 0, 0);

    for (int t = 0; t < 60; t++) begin
      int_vector = 8'($urandom);
      do_access($urandom_range(0, 5), 16'($urandom), 8'($urandom), 8'($urandom),
                $urandom_range(0, 6), ($urandom_range(0, 4) == 0), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
